// File: rtl/lsp_pkg.sv
// Shared constants, FSM encoding and freq_prev/fg row layout for the LSP
// MA-predictor blocks (writer, extractor and composer).
package lsp_pkg;

    localparam int M      = 10;
    localparam int MA_NP  = 4;
    localparam int ADDR_W = 11;

    // Row layout of freq_prev and fg tables: k at [5:4], j at [3:0].
    localparam int J_W = 4;
    localparam int K_W = 2;

    localparam logic [J_W-1:0] J_LAST = J_W'(M - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(MA_NP - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_RD_ELE,
        S_RD_FGS,
        S_MULT,
        S_RD_FP,
        S_RD_FG,
        S_MAC,
        S_WRITE
    } state_t;

endpackage

// File: rtl/lsp_prev_compose.sv
// G.729 Lsp_prev_compose: lsp[j] = extract_h(L_mult(lsp_ele,fg_sum) + sum_k L_mac(freq_prev,fg)),
// sequenced over shared scratch memory and shared external L_mult/L_mac units.
module lsp_prev_compose
    import lsp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] lsp_eleAddr,
    input  logic [10:0] fg_sumAddr,
    input  logic [10:0] fgAddr,
    input  logic [10:0] freq_prevAddr,
    input  logic [10:0] lspAddr,
    input  logic [31:0] memIn,
    input  logic [31:0] L_multIn,
    input  logic [31:0] L_macIn,
    output logic [10:0] memReadAddr,
    output logic [10:0] memWriteAddr,
    output logic [31:0] memOut,
    output logic        memWriteEn,
    output logic [15:0] L_multOutA,
    output logic [15:0] L_multOutB,
    output logic [15:0] L_macOutA,
    output logic [15:0] L_macOutB,
    output logic [31:0] L_macOutC,
    output logic        done
);

    state_t         state, state_n;
    logic [J_W-1:0] j, j_n;
    logic [K_W-1:0] k, k_n;
    logic [15:0]    temp, temp_n;
    logic [31:0]    acc, acc_n;

    // Only the low half of a memory word carries data.
    logic unused_mem_hi;
    assign unused_mem_hi = ^memIn[31:16];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_INIT;
            j     <= '0;
            k     <= '0;
            temp  <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            j     <= j_n;
            k     <= k_n;
            temp  <= temp_n;
            acc   <= acc_n;
        end
    end

    always_comb begin
        state_n      = state;
        j_n          = j;
        k_n          = k;
        temp_n       = temp;
        acc_n        = acc;
        memReadAddr  = '0;
        memWriteAddr = '0;
        memOut       = '0;
        memWriteEn   = 1'b0;
        L_multOutA   = '0;
        L_multOutB   = '0;
        L_macOutA    = '0;
        L_macOutB    = '0;
        L_macOutC    = '0;
        done         = 1'b0;

        unique case (state)
            S_INIT: begin
                if (start) begin
                    j_n     = '0;
                    state_n = S_RD_ELE;
                end
            end
            S_RD_ELE: begin
                memReadAddr = {lsp_eleAddr[ADDR_W-1:J_W], j};
                state_n     = S_RD_FGS;
            end
            S_RD_FGS: begin
                temp_n      = memIn[15:0];
                memReadAddr = {fg_sumAddr[ADDR_W-1:J_W], j};
                state_n     = S_MULT;
            end
            S_MULT: begin
                L_multOutA = temp;
                L_multOutB = memIn[15:0];
                acc_n      = L_multIn;
                k_n        = '0;
                state_n    = S_RD_FP;
            end
            S_RD_FP: begin
                memReadAddr = {freq_prevAddr[ADDR_W-1:J_W+K_W], k, j};
                state_n     = S_RD_FG;
            end
            S_RD_FG: begin
                temp_n      = memIn[15:0];
                memReadAddr = {fgAddr[ADDR_W-1:J_W+K_W], k, j};
                state_n     = S_MAC;
            end
            S_MAC: begin
                L_macOutA = temp;
                L_macOutB = memIn[15:0];
                L_macOutC = acc;
                acc_n     = L_macIn;
                if (k == K_LAST) begin
                    state_n = S_WRITE;
                end else begin
                    k_n     = k + 1'b1;
                    state_n = S_RD_FP;
                end
            end
            S_WRITE: begin
                // extract_h is a plain truncation; rounding is not part of this step.
                memWriteAddr = {lspAddr[ADDR_W-1:J_W], j};
                memOut       = {{16{acc[31]}}, acc[31:16]};
                memWriteEn   = 1'b1;
                if (j == J_LAST) begin
                    done    = 1'b1;
                    state_n = S_INIT;
                end else begin
                    j_n     = j + 1'b1;
                    state_n = S_RD_ELE;
                end
            end
            default: state_n = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_lsp_prev_compose.sv
// Bench for lsp_prev_compose: memory and L_mult/L_mac unit models around the
// DUT, results checked against a direct evaluation of the compose formula.
module tb_lsp_prev_compose;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [10:0] lsp_eleAddr, fg_sumAddr, fgAddr, freq_prevAddr, lspAddr;
    logic [31:0] memIn = '0;
    logic [31:0] L_multIn, L_macIn;
    logic [10:0] memReadAddr, memWriteAddr;
    logic [31:0] memOut;
    logic        memWriteEn;
    logic [15:0] L_multOutA, L_multOutB, L_macOutA, L_macOutB;
    logic [31:0] L_macOutC;
    logic        done;

    int total = 0;
    int bad = 0;

    logic [15:0] mem  [0:2047];
    logic [15:0] snap [0:2047];
    logic [15:0] exp_q[$];
    logic [10:0] wr_addr_q[$];
    int          done_q[$];
    int          ext_bad;

    lsp_prev_compose dut (
        .clk(clk), .reset(reset), .start(start),
        .lsp_eleAddr(lsp_eleAddr), .fg_sumAddr(fg_sumAddr), .fgAddr(fgAddr),
        .freq_prevAddr(freq_prevAddr), .lspAddr(lspAddr),
        .memIn(memIn), .L_multIn(L_multIn), .L_macIn(L_macIn),
        .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr), .memOut(memOut),
        .memWriteEn(memWriteEn), .L_multOutA(L_multOutA), .L_multOutB(L_multOutB),
        .L_macOutA(L_macOutA), .L_macOutB(L_macOutB), .L_macOutC(L_macOutC),
        .done(done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- G.729 basic-op models ----------------
    function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
        int p;
        if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
        p = int'($signed(a)) * int'($signed(b));
        return 32'(p * 2);
    endfunction

    function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    assign L_multIn = l_mult(L_multOutA, L_multOutB);
    assign L_macIn  = l_add(L_macOutC, l_mult(L_macOutA, L_macOutB));

    // One-cycle read latency; upper half of read data is junk the DUT must ignore.
    always @(posedge clk) begin
        memIn <= {16'($urandom), mem[memReadAddr]};
        if (memWriteEn) mem[memWriteAddr] <= memOut[15:0];
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_lsp(input int j);
        logic [31:0] acc;
        acc = l_mult(snap[int'(lsp_eleAddr) + j], snap[int'(fg_sumAddr) + j]);
        for (int k = 0; k < 4; k++)
            acc = l_add(acc, l_mult(snap[int'(freq_prevAddr) + 16 * k + j],
                                    snap[int'(fgAddr) + 16 * k + j]));
        return acc[31:16];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_bases(input logic [10:0] out_base);
        lsp_eleAddr   = 11'h100;
        fg_sumAddr    = 11'h110;
        fgAddr        = 11'h200;
        freq_prevAddr = 11'h240;
        lspAddr       = out_base;
    endtask

    // kind 0: constant value, kind 1: random
    task automatic fill(input logic [10:0] base, input int count, input int kind, input logic [15:0] val);
        for (int i = 0; i < count; i++)
            mem[int'(base) + i] = (kind == 0) ? val : 16'($urandom);
    endtask

    task automatic prepare;
        for (int i = 0; i < 2048; i++) snap[i] = mem[i];
        exp_q.delete();
        for (int j = 0; j < 10; j++) exp_q.push_back(ref_lsp(j));
        wr_addr_q.delete();
        done_q.delete();
        ext_bad = 0;
    endtask

    task automatic kick;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
    endtask

    // Watches cycles 1..max_cycles after the start edge; start drops at
    // cycle start_off and is pulsed again at cycle pulse_at.
    task automatic watch(input int max_cycles, input int start_off, input int pulse_at);
        for (int n = 1; n <= max_cycles; n++) begin
            @(negedge clk);
            if (memWriteEn) begin
                wr_addr_q.push_back(memWriteAddr);
                if (memOut[31:16] !== {16{memOut[15]}}) ext_bad++;
            end
            if (done) done_q.push_back(n);
            if (n == start_off) start = 1'b0;
            if (n == pulse_at) start = 1'b1;
            if (n == pulse_at + 1) start = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({memReadAddr, memWriteAddr, memOut, memWriteEn, L_multOutA, L_multOutB,
             L_macOutA, L_macOutB, L_macOutC, done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rd=%h wr=%h we=%b done=%b required all zero",
                     memReadAddr, memWriteAddr, memWriteEn, done);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_gain;
        set_bases(11'h120);
        fill(11'h100, 16, 1, 0); fill(11'h110, 16, 0, 0);
        fill(11'h200, 64, 0, 0); fill(11'h240, 64, 1, 0);
        fill(11'h120, 16, 0, 16'hDEAD);
        prepare();
        kick(); watch(170, 1, -5);
        total++;
        if (done_q.size() != 1 || done_q[0] != 160) begin
            bad++;
            $display("FAIL zero_done: count=%0d first=%0d required one pulse at 160",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        total++;
        if (wr_addr_q.size() != 10) begin
            bad++;
            $display("FAIL zero_write_count: got %0d required 10", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 10; i++) begin
            total++;
            if (wr_addr_q[i] !== 11'(11'h120 + i)) begin
                bad++;
                $display("FAIL zero_write_addr[%0d]: got %h required %h", i, wr_addr_q[i], 11'(11'h120 + i));
            end
        end
        for (int j = 0; j < 10; j++) begin
            total++;
            if (mem[11'h120 + j] !== 16'h0000) begin
                bad++;
                $display("FAIL zero_lsp[%0d]: got %h required 0000", j, mem[11'h120 + j]);
            end
        end
    endtask

    task automatic test_half_gain;
        set_bases(11'h120);
        fill(11'h100, 16, 0, 16'd1000); fill(11'h110, 16, 0, 16'd16384);
        fill(11'h200, 64, 0, 0); fill(11'h240, 64, 1, 0);
        prepare();
        kick(); watch(165, 1, -5);
        for (int j = 0; j < 10; j++) begin
            total++;
            if (mem[11'h120 + j] !== 16'd500) begin
                bad++;
                $display("FAIL half_lsp[%0d]: got %0d required 500", j, mem[11'h120 + j]);
            end
        end
        total++;
        if (done_q.size() != 1) begin
            bad++;
            $display("FAIL half_done: got %0d pulses required 1", done_q.size());
        end
    endtask

    task automatic test_mac_only;
        set_bases(11'h120);
        fill(11'h100, 16, 1, 0); fill(11'h110, 16, 0, 0);
        fill(11'h200, 64, 0, 16'd8192); fill(11'h240, 64, 0, 16'd2000);
        prepare();
        kick(); watch(165, 1, -5);
        for (int j = 0; j < 10; j++) begin
            total++;
            if (mem[11'h120 + j] !== 16'd2000) begin
                bad++;
                $display("FAIL mac_lsp[%0d]: got %0d required 2000", j, mem[11'h120 + j]);
            end
        end
    endtask

    task automatic test_saturation;
        set_bases(11'h120);
        fill(11'h100, 16, 0, 16'h8000); fill(11'h110, 16, 0, 16'h8000);
        fill(11'h200, 64, 0, 0); fill(11'h240, 64, 1, 0);
        prepare();
        kick(); watch(165, 1, -5);
        for (int j = 0; j < 10; j++) begin
            total++;
            if (mem[11'h120 + j] !== 16'h7FFF) begin
                bad++;
                $display("FAIL sat_lsp[%0d]: got %h required 7fff", j, mem[11'h120 + j]);
            end
        end
        total++;
        if (ext_bad != 0) begin
            bad++;
            $display("FAIL sat_sign_ext: %0d writes with bad upper half, required 0", ext_bad);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            set_bases(11'h120);
            fill(11'h100, 16, 1, 0); fill(11'h110, 16, 1, 0);
            fill(11'h200, 64, 1, 0); fill(11'h240, 64, 1, 0);
            if (r == 2) fill(11'h200, 64, 0, 16'h8000); // drive L_mac toward saturation
            prepare();
            kick(); watch(165, 1, -5);
            for (int j = 0; j < 10; j++) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                total++;
                if (mem[11'h120 + j] !== e) begin
                    bad++;
                    $display("FAIL rand%0d_lsp[%0d]: got %h required %h", r, j, mem[11'h120 + j], e);
                end
            end
            total++;
            if (ext_bad != 0) begin
                bad++;
                $display("FAIL rand%0d_sign_ext: %0d bad writes required 0", r, ext_bad);
            end
        end
    endtask

    task automatic test_reset_mid;
        int late_writes;
        set_bases(11'h120);
        fill(11'h100, 16, 1, 0); fill(11'h110, 16, 1, 0);
        fill(11'h200, 64, 1, 0); fill(11'h240, 64, 1, 0);
        fill(11'h120, 16, 1, 0);
        prepare();
        kick();
        watch(50, 1, -5);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({memReadAddr, memWriteAddr, memOut, memWriteEn, L_multOutA, L_multOutB,
             L_macOutA, L_macOutB, L_macOutC, done} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: rd=%h we=%b multA=%h macC=%h required all zero",
                     memReadAddr, memWriteAddr, L_multOutA, L_macOutC);
        end
        late_writes = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (memWriteEn) late_writes++;
        end
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (memWriteEn || done) late_writes++;
        end
        total++;
        if (wr_addr_q.size() != 3 || late_writes != 0) begin
            bad++;
            $display("FAIL midreset_writes: before=%0d after=%0d required 3 and 0",
                     wr_addr_q.size(), late_writes);
        end
        for (int j = 0; j < 10; j++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (j >= 3) e = snap[11'h120 + j];
            total++;
            if (mem[11'h120 + j] !== e) begin
                bad++;
                $display("FAIL midreset_lsp[%0d]: got %h required %h", j, mem[11'h120 + j], e);
            end
        end
        prepare();
        kick(); watch(165, 1, -5);
        total++;
        if (done_q.size() != 1 || done_q[0] != 160) begin
            bad++;
            $display("FAIL restart_done: count=%0d first=%0d required one at 160",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        for (int j = 0; j < 10; j++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            total++;
            if (mem[11'h120 + j] !== e) begin
                bad++;
                $display("FAIL restart_lsp[%0d]: got %h required %h", j, mem[11'h120 + j], e);
            end
        end
    endtask

    task automatic test_busy_inplace;
        set_bases(11'h100);
        fill(11'h100, 16, 1, 0); fill(11'h110, 16, 1, 0);
        fill(11'h200, 64, 1, 0); fill(11'h240, 64, 1, 0);
        prepare();
        kick(); watch(200, 1, 30);
        total++;
        if (done_q.size() != 1 || done_q[0] != 160 || wr_addr_q.size() != 10) begin
            bad++;
            $display("FAIL busy_done: pulses=%0d first=%0d writes=%0d required 1 at 160 and 10 writes",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, wr_addr_q.size());
        end
        for (int j = 0; j < 10; j++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            total++;
            if (mem[11'h100 + j] !== e) begin
                bad++;
                $display("FAIL inplace_lsp[%0d]: got %h required %h", j, mem[11'h100 + j], e);
            end
        end
    endtask

    task automatic test_back_to_back;
        set_bases(11'h120);
        fill(11'h100, 16, 1, 0); fill(11'h110, 16, 1, 0);
        fill(11'h200, 64, 1, 0); fill(11'h240, 64, 1, 0);
        prepare();
        kick(); watch(340, 200, -5);
        total++;
        if (done_q.size() != 2 || done_q[0] != 160 || done_q[1] != 321) begin
            bad++;
            $display("FAIL b2b_done: pulses=%0d first=%0d second=%0d required 160 and 321",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1,
                     (done_q.size() > 1) ? done_q[1] : -1);
        end
        total++;
        if (wr_addr_q.size() != 20) begin
            bad++;
            $display("FAIL b2b_writes: got %0d required 20", wr_addr_q.size());
        end
        for (int j = 0; j < 10; j++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            total++;
            if (mem[11'h120 + j] !== e) begin
                bad++;
                $display("FAIL b2b_lsp[%0d]: got %h required %h", j, mem[11'h120 + j], e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        set_bases(11'h120);
        test_reset();
        test_zero_gain();
        test_half_gain();
        test_mac_only();
        test_saturation();
        test_random();
        test_reset_mid();
        test_busy_inplace();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
